// File: rtl/teclado_pkg.sv
// Shared constants, FIFO entry layout and capture FSM states for the
// PS/2 scan-code decoder.
package teclado_pkg;

   // Prefix and keyboard control/response codes
   localparam logic [7:0] PREF_EXT    = 8'hE0;
   localparam logic [7:0] PREF_SOLTAR = 8'hF0;
   localparam logic [7:0] ACK         = 8'hFA;
   localparam logic [7:0] BAT_OK      = 8'hAA;
   localparam logic [7:0] REENVIO     = 8'hFE;
   localparam logic [7:0] ERR0        = 8'h00;
   localparam logic [7:0] ERR1        = 8'hFF;

   // FIFO entry: {ext, brk, code[7:0]}
   localparam int ENTRADA_W = 10;

   typedef enum logic {
      ESPERA = 1'b0,
      LIBERA = 1'b1
   } estado_t;

   // Bytes that are keyboard housekeeping rather than key codes
   function automatic logic es_control(input logic [7:0] b);
      return (b == ERR0) || (b == BAT_OK) || (b == ACK) ||
             (b == REENVIO) || (b == ERR1);
   endfunction

endpackage

// File: rtl/fifo_teclado.sv
// First-word-fall-through FIFO for decoded key events. The head entry is
// kept in a register so it is clean out of reset and holds when empty.
module fifo_teclado
   import teclado_pkg::*;
#(
   parameter int PROFUNDIDAD = 8,
   parameter int ENTRADA_W_P = ENTRADA_W,
   localparam int AW = $clog2(PROFUNDIDAD)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [ENTRADA_W_P-1:0] wdata,
   input  logic                   pop,
   output logic [ENTRADA_W_P-1:0] cabeza,
   output logic                   hay_dato,
   output logic [AW:0]            ocupacion,
   output logic                   perdida
);

   logic [ENTRADA_W_P-1:0] mem [PROFUNDIDAD];
   logic [AW-1:0]          rd_q, wr_q, rd_d;
   logic [AW:0]            cnt_q, cnt_d, cnt_tras_pop;
   logic [ENTRADA_W_P-1:0] cabeza_q, cabeza_d;
   logic                   vacio, lleno, pop_ok, push_ok;

   assign vacio   = (cnt_q == '0);
   assign lleno   = (cnt_q == (AW+1)'(PROFUNDIDAD));
   assign pop_ok  = pop & ~vacio;
   // A pop in the same cycle frees the slot the push needs
   assign push_ok = push & (~lleno | pop_ok);
   assign perdida = push & lleno & ~pop_ok;

   // Next pointers, occupancy and the head entry visible next cycle
   always_comb begin
      rd_d         = rd_q + AW'(pop_ok);
      cnt_tras_pop = cnt_q - (AW+1)'(pop_ok);
      cnt_d        = cnt_tras_pop + (AW+1)'(push_ok);
      cabeza_d     = cabeza_q;
      if (cnt_d != '0) begin
         // Writing into an otherwise empty FIFO: the new entry falls through
         if (cnt_tras_pop == '0)
            cabeza_d = wdata;
         else
            cabeza_d = mem[rd_d];
      end
   end

   // Storage array
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_q] <= wdata;
   end

   // Pointers, occupancy and head register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         cabeza_q <= '0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_q + AW'(push_ok);
         cnt_q    <= cnt_d;
         cabeza_q <= cabeza_d;
      end
   end

   assign cabeza    = cabeza_q;
   assign hay_dato  = ~vacio;
   assign ocupacion = cnt_q;

endmodule

// File: rtl/decodificador_teclado.sv
// Acknowledges scan-code bytes from the PS/2 reader, folds E0/F0 prefixes
// into make/break/extended events and queues them for the PicoBlaze.
module decodificador_teclado
   import teclado_pkg::*;
#(
   parameter int PROFUNDIDAD = 8,
   localparam int AW = $clog2(PROFUNDIDAD)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [7:0]    TECLA,
   input  logic          interrupcion,
   output logic          interrupcion_paro,
   input  logic          leer,
   input  logic          limpiar_desborde,
   output logic [7:0]    dato,
   output logic          soltada,
   output logic          extendida,
   output logic          hay_dato,
   output logic [AW:0]   ocupacion,
   output logic          desborde
);

   estado_t                estado_q, estado_d;
   logic                   int_q;
   logic [7:0]             tecla_q;
   logic                   paro_q, paro_d;
   logic                   ext_q, ext_d, brk_q, brk_d;
   logic                   push;
   logic                   perdida;
   logic [ENTRADA_W-1:0]   entrada, cabeza;
   logic                   desborde_q;

   // Byte-available level, registered from the reader
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         int_q <= 1'b0;
      else
         int_q <= interrupcion;
   end

   // Scan-code byte latched alongside the level; only used while int_q=1
   always_ff @(posedge CLK) begin
      tecla_q <= TECLA;
   end

   // Capture FSM state, acknowledge and prefix flags
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         estado_q <= ESPERA;
         paro_q   <= 1'b0;
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         paro_q   <= paro_d;
         ext_q    <= ext_d;
         brk_q    <= brk_d;
      end
   end

   // Next state, acknowledge and byte decode on the ESPERA->LIBERA edge
   always_comb begin
      estado_d = estado_q;
      paro_d   = paro_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      push     = 1'b0;
      case (estado_q)
         ESPERA: begin
            if (int_q) begin
               estado_d = LIBERA;
               paro_d   = 1'b1;
               if (tecla_q == PREF_EXT) begin
                  ext_d = 1'b1;
               end else if (tecla_q == PREF_SOLTAR) begin
                  brk_d = 1'b1;
               end else begin
                  push  = ~es_control(tecla_q);
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         end
         LIBERA: begin
            // Released as soon as the reader drops its level
            if (!interrupcion) begin
               estado_d = ESPERA;
               paro_d   = 1'b0;
            end
         end
         default: begin
            estado_d = ESPERA;
            paro_d   = 1'b0;
         end
      endcase
   end

   assign entrada = {ext_q, brk_q, tecla_q};

   fifo_teclado #(
      .PROFUNDIDAD (PROFUNDIDAD),
      .ENTRADA_W_P (ENTRADA_W)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST),
      .push      (push),
      .wdata     (entrada),
      .pop       (leer),
      .cabeza    (cabeza),
      .hay_dato  (hay_dato),
      .ocupacion (ocupacion),
      .perdida   (perdida)
   );

   // Sticky overflow flag; a new loss beats a simultaneous clear
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         desborde_q <= 1'b0;
      else if (perdida)
         desborde_q <= 1'b1;
      else if (limpiar_desborde)
         desborde_q <= 1'b0;
   end

   assign interrupcion_paro = paro_q;
   assign dato              = cabeza[7:0];
   assign soltada           = cabeza[8];
   assign extendida         = cabeza[9];
   assign desborde          = desborde_q;

endmodule

// File: tb/tb_decodificador_teclado.sv
// Directed bench for decodificador_teclado with a queue-based scoreboard.
module tb_decodificador_teclado;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] TECLA;
   logic       interrupcion;
   logic       interrupcion_paro;
   logic       leer;
   logic       limpiar_desborde;
   logic [7:0] dato;
   logic       soltada;
   logic       extendida;
   logic       hay_dato;
   logic [3:0] ocupacion;
   logic       desborde;

   int n_checks = 0;
   int n_fail   = 0;

   logic [9:0] esperado [$];

   decodificador_teclado #(.PROFUNDIDAD(8)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .TECLA             (TECLA),
      .interrupcion      (interrupcion),
      .interrupcion_paro (interrupcion_paro),
      .leer              (leer),
      .limpiar_desborde  (limpiar_desborde),
      .dato              (dato),
      .soltada           (soltada),
      .extendida         (extendida),
      .hay_dato          (hay_dato),
      .ocupacion         (ocupacion),
      .desborde          (desborde)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, exp, $time);
      end
   endtask

   // One byte through the reader handshake; optionally pop on the push edge
   task automatic send(input logic [7:0] b, input bit leer_en_push);
      @(posedge CLK); #1;
      TECLA = b;
      interrupcion = 1'b1;
      @(posedge CLK); #1;
      chk("paro_antes", interrupcion_paro, 1'b0);
      if (leer_en_push) leer = 1'b1;
      @(posedge CLK); #1;
      leer = 1'b0;
      chk("paro_sube", interrupcion_paro, 1'b1);
      interrupcion = 1'b0;
      @(posedge CLK); #1;
      chk("paro_baja", interrupcion_paro, 1'b0);
   endtask

   task automatic pop1();
      @(posedge CLK); #1;
      leer = 1'b1;
      @(posedge CLK); #1;
      leer = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_paro"}, interrupcion_paro, 1'b0);
      chk({tag, "_dato"}, dato, 8'h00);
      chk({tag, "_soltada"}, soltada, 1'b0);
      chk({tag, "_extendida"}, extendida, 1'b0);
      chk({tag, "_hay_dato"}, hay_dato, 1'b0);
      chk({tag, "_ocupacion"}, ocupacion, 4'd0);
      chk({tag, "_desborde"}, desborde, 1'b0);
   endtask

   // Monitor: every accepted pop is compared with the oldest expected entry
   always @(negedge CLK) begin
      if (RST === 1'b1 && leer === 1'b1) begin
         if (hay_dato === 1'b1) begin
            if (esperado.size() == 0)
               chk("entrada_inesperada", {extendida, soltada, dato}, 10'h3FF);
            else
               chk("entrada", {extendida, soltada, dato}, esperado.pop_front());
         end else if (esperado.size() != 0) begin
            chk("entrada_ausente", hay_dato, 1'b1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b0;
      TECLA = 8'h00;
      interrupcion = 1'b0;
      leer = 1'b0;
      limpiar_desborde = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset("reset");
      RST = 1'b1;

      // Make code with explicit latency checks
      @(posedge CLK); #1;
      TECLA = 8'h1C;
      interrupcion = 1'b1;
      @(posedge CLK); #1;
      chk("t1_paro_antes", interrupcion_paro, 1'b0);
      chk("t1_hay_antes", hay_dato, 1'b0);
      esperado.push_back({2'b00, 8'h1C});
      @(posedge CLK); #1;
      chk("t1_paro_sube", interrupcion_paro, 1'b1);
      chk("t1_hay_dato", hay_dato, 1'b1);
      chk("t1_ocupacion", ocupacion, 4'd1);
      // Held longer than needed: still a single byte
      @(posedge CLK); #1;
      chk("t1_paro_mantiene", interrupcion_paro, 1'b1);
      chk("t1_un_byte", ocupacion, 4'd1);
      interrupcion = 1'b0;
      @(posedge CLK); #1;
      chk("t1_paro_baja", interrupcion_paro, 1'b0);
      pop1();
      chk("t1_vacia", ocupacion, 4'd0);

      // Extended break followed by a plain make
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      chk("t2_prefijos_sin_push", ocupacion, 4'd0);
      esperado.push_back({2'b11, 8'h74});
      send(8'h74, 1'b0);
      esperado.push_back({2'b00, 8'h1C});
      send(8'h1C, 1'b0);
      chk("t2_ocupacion", ocupacion, 4'd2);
      pop1();
      pop1();

      // Control bytes are dropped and clear a pending break
      send(8'hFA, 1'b0);
      send(8'hAA, 1'b0);
      send(8'hF0, 1'b0);
      send(8'hFE, 1'b0);
      esperado.push_back({2'b00, 8'h29});
      send(8'h29, 1'b0);
      chk("t3_ocupacion", ocupacion, 4'd1);
      pop1();

      // Overflow: nine pushes into eight slots
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) esperado.push_back({2'b00, 8'(i)});
         send(8'(i), 1'b0);
      end
      chk("t4_ocupacion_llena", ocupacion, 4'd8);
      chk("t4_desborde", desborde, 1'b1);
      chk("t4_cabeza", dato, 8'h01);
      @(posedge CLK); #1;
      limpiar_desborde = 1'b1;
      @(posedge CLK); #1;
      limpiar_desborde = 1'b0;
      chk("t4_limpiar", desborde, 1'b0);

      // Full FIFO, pop on the push edge: no loss, head advances
      esperado.push_back({2'b00, 8'h0A});
      send(8'h0A, 1'b1);
      chk("t5_sin_desborde", desborde, 1'b0);
      chk("t5_ocupacion", ocupacion, 4'd8);
      chk("t5_cabeza", dato, 8'h02);
      for (int i = 0; i < 8; i++) pop1();
      chk("t5_vacia", ocupacion, 4'd0);
      chk("t5_hay_dato", hay_dato, 1'b0);

      // Pop while empty is ignored
      pop1();
      chk("vacia_leer_ocup", ocupacion, 4'd0);
      chk("vacia_leer_hay", hay_dato, 1'b0);

      // Reset after a pending E0 prefix drops the prefix
      send(8'hE0, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset("t6_reset");
      RST = 1'b1;
      esperado.push_back({2'b00, 8'h75});
      send(8'h75, 1'b0);
      chk("t6_dato", dato, 8'h75);
      chk("t6_extendida", extendida, 1'b0);
      pop1();

      chk("cola_vacia", esperado.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decodificador_teclado.md
Name: decodificador_teclado

Overview:
- Downstream consumer of the PS/2 keyboard reader.
- Takes each received scan-code byte (TECLA plus its level-held interrupcion flag) and acknowledges it through interrupcion_paro.
- Folds E0/F0 prefixes into make/break/extended key events and buffers them in a FWFT FIFO.
- The PicoBlaze reads the FIFO through simple pop/status signals.

Parameters:
- PROFUNDIDAD, 8, FIFO depth in entries; power of two, 2..64.
- AW, $clog2(PROFUNDIDAD), FIFO pointer width; derived, not to be overridden.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- TECLA  in  8  scan-code byte from the keyboard reader; valid while interrupcion=1.
- interrupcion  in  1  byte-available level from the reader; stays high until acknowledged.
- interrupcion_paro  out  1  acknowledge to the reader.
- leer  in  1  one-cycle pop strobe from the PicoBlaze port logic.
- limpiar_desborde  in  1  clears the desborde flag.
- dato  out  8  scan code of the FIFO head.
- soltada  out  1  head entry is a break (key released).
- extendida  out  1  head entry carried the E0 prefix.
- hay_dato  out  1  FIFO not empty; drives the PicoBlaze interrupt.
- ocupacion  out  AW+1  number of entries held.
- desborde  out  1  sticky flag: an event was lost because the FIFO was full.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to ESPERA; flags ext and brk clear; FIFO empty.
  - All outputs 0: interrupcion_paro, dato, soltada, extendida, hay_dato, ocupacion, desborde.
- Capture FSM, 2 states:
  - ESPERA: on interrupcion=1, latch TECLA, set interrupcion_paro=1 on the next edge, go to LIBERA.
  - LIBERA: hold interrupcion_paro=1 until interrupcion=0 is sampled. On that edge drive interrupcion_paro=0 and return to ESPERA.
  - Exactly one byte is consumed per interrupcion high period, regardless of its length.
- Decode, evaluated on the ESPERA->LIBERA edge using TECLA:
  - 0xE0: ext<=1; nothing pushed.
  - 0xF0: brk<=1; nothing pushed.
  - 0x00, 0xAA, 0xFA, 0xFE, 0xFF: discarded; ext<=0, brk<=0.
  - Any other byte: push {ext, brk, TECLA}; then ext<=0, brk<=0.
  - E0 F0 xx and F0 alone both work; a repeated prefix is idempotent.
- Latency: interrupcion sampled high at edge n -> entry visible (hay_dato=1, dato valid) after edge n+1. interrupcion_paro is also high after edge n+1.
- FIFO:
  - First-word-fall-through; dato, soltada and extendida always show the head.
  - Head outputs hold their last value when empty; their content is don't-care while hay_dato=0.
  - Pointers wrap modulo PROFUNDIDAD.
  - ocupacion is exact, 0..PROFUNDIDAD.
- Pop: leer=1 with hay_dato=1 removes the head; the new head is visible the next cycle. leer while empty is ignored; ocupacion stays 0.
- Push when full:
  - Without a simultaneous pop: entry dropped, desborde<=1, ocupacion unchanged.
  - With leer in the same cycle: pop then push; no overflow, ocupacion stays PROFUNDIDAD.
- Push and pop in the same cycle when not full: ocupacion unchanged.
- desborde: sticky. limpiar_desborde=1 clears it. If a new overflow and limpiar_desborde occur in the same cycle, the set wins.
- Reset mid-operation (e.g. after E0 received, or in LIBERA): everything returns to reset values; a pending prefix is lost. If interrupcion is still high after reset, the byte is re-acknowledged as a new byte.

Decomposition:
- Package teclado_pkg holds:
  - Prefix/control code constants: PREF_EXT=8'hE0, PREF_SOLTAR=8'hF0, ACK=8'hFA, BAT_OK=8'hAA, REENVIO=8'hFE, ERR0=8'h00, ERR1=8'hFF.
  - FIFO entry width constant ENTRADA_W=10, field order {ext, brk, code[7:0]}.
  - FSM state encodings ESPERA/LIBERA.
- Sub-module fifo_teclado (parameters PROFUNDIDAD, ENTRADA_W): FWFT, full/empty, occupancy, overflow. The top holds only the capture FSM, the decode logic and the desborde handling.

Test Plan:
- Make code: TECLA=0x1C held until ack -> one entry dato=0x1C, soltada=0, extendida=0. interrupcion_paro rises 1 cycle after interrupcion and falls 1 cycle after interrupcion drops.
- Extended break: bytes E0, F0, 74 -> exactly one entry dato=0x74, soltada=1, extendida=1; next byte 0x1C -> entry with flags 0/0.
- Control bytes: FA, AA, then F0 followed by FE, then 0x29 -> only one entry, dato=0x29, soltada=0 (FE cleared brk).
- Overflow (PROFUNDIDAD=8): push 9 codes 0x01..0x09 without reads -> ocupacion=8, desborde=1; reads return 0x01..0x08 in order. limpiar_desborde -> desborde=0.
- Full with simultaneous pop/push: FIFO full, leer on the push cycle -> no desborde, ocupacion stays 8, head advances.
- Reset mid-prefix: send E0, assert RST=0 for 3 cycles -> all outputs 0. Then send 0x75 -> entry extendida=0. Also: leer on empty -> ocupacion stays 0.
